// File: rtl/plru_victim_walk_if.sv
// Request/response bundle between the miss FSM and the tree-PLRU victim walker.
// Optional: PLRU_INVALID_FIRST_EN adds way_valid so an empty way is chosen first.
interface plru_victim_walk_if #(
   parameter int unsigned s_assoc = 8
);
   localparam int unsigned s_width = $clog2(s_assoc);
   localparam int unsigned tree_w  = s_assoc - 1;

   logic                start;
   logic [tree_w-1:0]   lru_bits;
   logic                invalidate;
`ifdef PLRU_INVALID_FIRST_EN
   logic [s_assoc-1:0]  way_valid;
`endif
   logic                ready;
   logic                victim_valid;
   logic [s_width-1:0]  victim_way;
   logic [tree_w-1:0]   path_mask;

   // Requester side (cache controller miss FSM)
   modport master (
      output start, lru_bits, invalidate,
`ifdef PLRU_INVALID_FIRST_EN
      output way_valid,
`endif
      input  ready, victim_valid, victim_way, path_mask
   );

   // Walker side
   modport slave (
      input  start, lru_bits, invalidate,
`ifdef PLRU_INVALID_FIRST_EN
      input  way_valid,
`endif
      output ready, victim_valid, victim_way, path_mask
   );
endinterface

// File: rtl/plru_victim_walk.sv
// Tree-PLRU victim selector: walks the heap-ordered LRU tree root to leaf,
// one level per clock, and reports the victim way plus the visited-node mask.
// Optional: PLRU_INVALID_FIRST_EN picks the lowest invalid way in one cycle.
module plru_victim_walk #(
   parameter int unsigned s_assoc = 8
) (
   input logic               clk,
   input logic               rst_n,
   plru_victim_walk_if.slave bus
);
   localparam int unsigned s_width = $clog2(s_assoc);
   localparam int unsigned node_w  = s_width + 1;
   localparam int unsigned tree_w  = s_assoc - 1;

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t              state, state_nxt;
   logic [node_w-1:0]   node, node_nxt;
   logic [s_width-1:0]  level;
   logic [tree_w-1:0]   snap, snap_shift;
   logic [tree_w-1:0]   path_mask;
   logic [s_width-1:0]  victim_way;
   logic                go_right;
   logic                accept, walk_step, last_step, abort;
   logic                any_invalid;
   logic [s_width-1:0]  first_invalid;

`ifdef PLRU_INVALID_FIRST_EN
   // Lowest-index invalid way; descending scan so the smallest index wins
   always_comb begin
      any_invalid   = 1'b0;
      first_invalid = '0;
      for (int i = int'(s_assoc) - 1; i >= 0; i--) begin
         if (!bus.way_valid[i]) begin
            any_invalid   = 1'b1;
            first_invalid = s_width'(i);
         end
      end
   end
`else
   assign any_invalid   = 1'b0;
   assign first_invalid = '0;
`endif

   // Child select: parent -> child = 2*node + 1 + snap[node]
   always_comb begin
      snap_shift = snap >> node;
      go_right   = snap_shift[0];
      node_nxt   = {node[node_w-2:0], 1'b0} + node_w'(1) + node_w'(go_right);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start && !bus.invalidate) state_nxt = any_invalid ? DONE : WALK;
         WALK: if (bus.invalidate)               state_nxt = IDLE;
               else if (last_step)               state_nxt = DONE;
         DONE:                                   state_nxt = IDLE;
         default:                                state_nxt = IDLE;
      endcase
   end

   // Output and datapath-control decode
   always_comb begin
      bus.ready        = 1'b0;
      bus.victim_valid = 1'b0;
      accept           = 1'b0;
      walk_step        = 1'b0;
      last_step        = 1'b0;
      abort            = 1'b0;
      case (state)
         IDLE: begin
            bus.ready = 1'b1;
            accept    = bus.start && !bus.invalidate;
         end
         WALK: begin
            abort     = bus.invalidate;
            walk_step = !bus.invalidate;
            last_step = (level == s_width'(s_width - 1));
         end
         DONE: begin
            abort            = bus.invalidate;
            bus.victim_valid = !bus.invalidate;
         end
         default: ;
      endcase
   end

   // Snapshot, walk pointer, visited mask and victim registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap       <= '0;
         node       <= '0;
         level      <= '0;
         path_mask  <= '0;
         victim_way <= '0;
      end else if (accept) begin
         snap      <= bus.lru_bits;
         node      <= '0;
         level     <= '0;
         path_mask <= '0;
         if (any_invalid) victim_way <= first_invalid;
      end else if (abort) begin
         path_mask <= '0;
      end else if (walk_step) begin
         path_mask <= path_mask | (tree_w'(1) << node);
         node      <= node_nxt;
         level     <= level + s_width'(1);
         if (last_step) victim_way <= s_width'(node_nxt - node_w'(tree_w));
      end
   end

   assign bus.victim_way = victim_way;
   assign bus.path_mask  = path_mask;
endmodule

// File: tb/tb_plru_victim_walk.sv
// Directed + randomized bench for plru_victim_walk against a tree-descent model.
// Optional: PLRU_INVALID_FIRST_EN enables the invalid-way-first checks.
module tb_plru_victim_walk;
   localparam int unsigned SA = 8;
   localparam int unsigned SW = $clog2(SA);
   localparam int unsigned TW = SA - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;
   int   held_way = 0;

   always #5 clk = ~clk;

   plru_victim_walk_if #(.s_assoc(SA)) bus_if ();
   plru_victim_walk #(.s_assoc(SA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Victim = descend from root; at each level the tree bit is the next way bit (MSB first)
   function automatic void ref_walk(input logic [TW-1:0] bits, output int way, output int mask);
      int n;
      n = 0; way = 0; mask = 0;
      for (int l = 0; l < int'(SW); l++) begin
         mask = mask | (1 << n);
         way  = way * 2 + int'(bits[n]);
         n    = 2 * n + 1 + int'(bits[n]);
      end
   endfunction

   // One full walk from IDLE; optionally change lru_bits right after the accept edge
   task automatic walk(input logic [TW-1:0] bits, input bit use_late, input logic [TW-1:0] late);
      int w, m;
      ref_walk(bits, w, m);
      bus_if.lru_bits = bits;
      bus_if.start    = 1'b1;
      check("idle_ready", 32'(bus_if.ready), 32'd1);
      step();
      bus_if.start = 1'b0;
      if (use_late) bus_if.lru_bits = late;
      for (int k = 0; k < int'(SW); k++) begin
         check("busy_ready", 32'(bus_if.ready), 32'd0);
         check("busy_valid", 32'(bus_if.victim_valid), 32'd0);
         step();
      end
      check("done_valid", 32'(bus_if.victim_valid), 32'd1);
      check("done_way", 32'(bus_if.victim_way), 32'(w));
      check("done_mask", 32'(bus_if.path_mask), 32'(m));
      step();
      check("post_ready", 32'(bus_if.ready), 32'd1);
      check("post_valid", 32'(bus_if.victim_valid), 32'd0);
      check("hold_way", 32'(bus_if.victim_way), 32'(w));
      check("hold_mask", 32'(bus_if.path_mask), 32'(m));
      held_way = w;
   endtask

   initial begin
      int w, m;
      bus_if.start      = 1'b0;
      bus_if.invalidate = 1'b0;
      bus_if.lru_bits   = '0;
`ifdef PLRU_INVALID_FIRST_EN
      bus_if.way_valid  = '1;
`endif
      step();
      step();
      check("rst_ready", 32'(bus_if.ready), 32'd1);
      check("rst_valid", 32'(bus_if.victim_valid), 32'd0);
      check("rst_way", 32'(bus_if.victim_way), 32'd0);
      check("rst_mask", 32'(bus_if.path_mask), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed tree patterns
      walk(7'h00, 1'b0, 7'h00);
      check("dir00_way", 32'(bus_if.victim_way), 32'd0);
      check("dir00_mask", 32'(bus_if.path_mask), 32'h0B);
      walk(7'h7F, 1'b0, 7'h00);
      check("dir7f_way", 32'(bus_if.victim_way), 32'd7);
      check("dir7f_mask", 32'(bus_if.path_mask), 32'h45);
      walk(7'h21, 1'b1, 7'h00);
      check("snap_way", 32'(bus_if.victim_way), 32'd5);
      check("snap_mask", 32'(bus_if.path_mask), 32'h25);

      // Abort in the second WALK cycle
      bus_if.lru_bits = 7'h7F;
      bus_if.start    = 1'b1;
      step();
      bus_if.start = 1'b0;
      step();
      bus_if.invalidate = 1'b1;
      #1;
      check("abort_walk_valid", 32'(bus_if.victim_valid), 32'd0);
      step();
      bus_if.invalidate = 1'b0;
      check("abort_ready", 32'(bus_if.ready), 32'd1);
      check("abort_mask", 32'(bus_if.path_mask), 32'd0);
      check("abort_way_hold", 32'(bus_if.victim_way), 32'(held_way));
      step();
      check("abort_no_pulse", 32'(bus_if.victim_valid), 32'd0);
      walk(7'h12, 1'b0, 7'h00);

      // Abort during DONE: pulse suppressed, mask cleared, freshly computed way kept
      ref_walk(7'h55, w, m);
      bus_if.lru_bits = 7'h55;
      bus_if.start    = 1'b1;
      step();
      bus_if.start = 1'b0;
      for (int k = 0; k < int'(SW); k++) step();
      bus_if.invalidate = 1'b1;
      #1;
      check("done_abort_valid", 32'(bus_if.victim_valid), 32'd0);
      step();
      bus_if.invalidate = 1'b0;
      check("done_abort_ready", 32'(bus_if.ready), 32'd1);
      check("done_abort_mask", 32'(bus_if.path_mask), 32'd0);
      check("done_abort_way", 32'(bus_if.victim_way), 32'(w));

      // start + invalidate together in IDLE: no walk
      bus_if.start      = 1'b1;
      bus_if.invalidate = 1'b1;
      step();
      bus_if.start      = 1'b0;
      bus_if.invalidate = 1'b0;
      check("both_ready", 32'(bus_if.ready), 32'd1);
      step();
      check("both_valid", 32'(bus_if.victim_valid), 32'd0);

      // start held high: one pulse every SW+2 cycles
      bus_if.lru_bits = 7'h00;
      bus_if.start    = 1'b1;
      step();
      for (int k = 0; k < 14; k++) begin
         check("held_valid", 32'(bus_if.victim_valid), 32'((k % int'(SW + 2)) == int'(SW)));
         check("held_ready", 32'(bus_if.ready), 32'((k % int'(SW + 2)) == int'(SW + 1)));
         step();
      end
      bus_if.start = 1'b0;
      for (int k = 0; k < int'(SW + 2); k++) step();
      check("held_idle", 32'(bus_if.ready), 32'd1);

      // Async reset mid-walk
      bus_if.lru_bits = 7'h7F;
      bus_if.start    = 1'b1;
      step();
      bus_if.start = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(bus_if.ready), 32'd1);
      check("midrst_valid", 32'(bus_if.victim_valid), 32'd0);
      check("midrst_way", 32'(bus_if.victim_way), 32'd0);
      check("midrst_mask", 32'(bus_if.path_mask), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("midrst_no_pulse", 32'(bus_if.victim_valid), 32'd0);

`ifdef PLRU_INVALID_FIRST_EN
      // Invalid way present: one-cycle latency, no tree walk
      bus_if.way_valid = 8'hF3;
      bus_if.lru_bits  = 7'h7F;
      bus_if.start     = 1'b1;
      step();
      bus_if.start     = 1'b0;
      bus_if.way_valid = '1;
      check("inv_valid", 32'(bus_if.victim_valid), 32'd1);
      check("inv_way", 32'(bus_if.victim_way), 32'd2);
      check("inv_mask", 32'(bus_if.path_mask), 32'd0);
      step();
      check("inv_ready", 32'(bus_if.ready), 32'd1);
      walk(7'h00, 1'b0, 7'h00);
`endif

      // Randomized walks against the model
      for (int r = 0; r < 30; r++) begin
         logic [TW-1:0] b, lb;
         b  = TW'($urandom);
         lb = TW'($urandom);
         walk(b, 1'($urandom_range(0, 1)), lb);
         if ($urandom_range(0, 2) == 0) step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
